// File: rtl/regfile_sb.sv
// Register file with per-register busy (scoreboard) bits.
// It has two combinational read ports with write bypass, and one write port that can
// extend the written field to the full register width.
// A sticky waw_err flags a busy_set issued to a register that still has a result outstanding.
module regfile_sb #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NREGS   = 16,
    parameter int unsigned ZERO_R0 = 0,
    localparam int unsigned SELW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [SELW-1:0] wr_sel,
    input  logic [1:0]      wr_width,
    input  logic            wr_sext,
    input  logic [XLEN-1:0] wr_data,
    input  logic [SELW-1:0] rda_sel,
    input  logic [SELW-1:0] rdb_sel,
    output logic [XLEN-1:0] rda_data,
    output logic [XLEN-1:0] rdb_data,
    input  logic            busy_set,
    input  logic [SELW-1:0] busy_sel,
    output logic            rda_busy,
    output logic            rdb_busy,
    output logic            any_busy,
    output logic            waw_err
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic            waw_q, waw_d;
    logic [XLEN-1:0] wr_val;
    logic [XLEN-1:0] keep;
    logic            sign;
    logic            wr_eff, bs_eff;

    // Register 0 is hard-wired when ZERO_R0 is set, so writes and marks to it are dropped.
    assign wr_eff = wr_en && !((ZERO_R0 != 0) && (wr_sel == '0));
    assign bs_eff = busy_set && !((ZERO_R0 != 0) && (busy_sel == '0));

    // Build the extended write value: keep the selected low field, fill the rest.
    always_comb begin
        keep = '1;
        sign = wr_data[XLEN-1];
        unique case (wr_width)
            2'd0: begin
                keep = {XLEN{1'b1}} >> (XLEN - 8);
                sign = wr_data[7];
            end
            2'd1: begin
                keep = {XLEN{1'b1}} >> (XLEN - 16);
                sign = wr_data[15];
            end
            2'd2: begin
                // For XLEN=32 this is the full register, identical to width 3.
                keep = {XLEN{1'b1}} >> (XLEN - 32);
                sign = wr_data[31];
            end
            default: begin
                keep = '1;
                sign = wr_data[XLEN-1];
            end
        endcase
        wr_val = (wr_data & keep) | ({XLEN{wr_sext & sign}} & ~keep);
    end

    // Read port A: stored value, or the in-flight write when it targets the same register.
    always_comb begin
        rda_data = regs_q[rda_sel];
        rda_busy = busy_q[rda_sel];
        if (wr_eff && (wr_sel == rda_sel)) begin
            rda_data = wr_val;
            // A completing write hides the busy bit unless it is re-marked this cycle.
            if (!(bs_eff && (busy_sel == rda_sel))) rda_busy = 1'b0;
        end
        if ((ZERO_R0 != 0) && (rda_sel == '0)) begin
            rda_data = '0;
            rda_busy = 1'b0;
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        rdb_data = regs_q[rdb_sel];
        rdb_busy = busy_q[rdb_sel];
        if (wr_eff && (wr_sel == rdb_sel)) begin
            rdb_data = wr_val;
            if (!(bs_eff && (busy_sel == rdb_sel))) rdb_busy = 1'b0;
        end
        if ((ZERO_R0 != 0) && (rdb_sel == '0)) begin
            rdb_data = '0;
            rdb_busy = 1'b0;
        end
    end

    // Next busy vector and error flag; a busy mark wins over a completing write.
    always_comb begin
        busy_d = busy_q;
        waw_d  = waw_q;
        if (bs_eff && busy_q[busy_sel] && !(wr_eff && (wr_sel == busy_sel))) waw_d = 1'b1;
        if (wr_eff) busy_d[wr_sel] = 1'b0;
        if (bs_eff) busy_d[busy_sel] = 1'b1;
    end

    // State update; reset overrides any write or busy mark in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
            busy_q <= '0;
            waw_q  <= 1'b0;
        end else begin
            if (wr_eff) regs_q[wr_sel] <= wr_val;
            busy_q <= busy_d;
            waw_q  <= waw_d;
        end
    end

    assign any_busy = |busy_q;
    assign waw_err  = waw_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 64-bit instance and a 32-bit instance with a hard-wired register 0,
// both driven by the same stimulus and compared against an array-based reference model.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [1:0]  wr_width;
    logic        wr_sext;
    logic [63:0] wr_data;
    logic [3:0]  rda_sel, rdb_sel;
    logic        busy_set;
    logic [3:0]  busy_sel;

    logic [63:0] a_rda, a_rdb;
    logic        a_rab, a_rbb, a_any, a_waw;
    logic [31:0] b_rda, b_rdb;
    logic        b_rab, b_rbb, b_any, b_waw;

    int checks = 0;
    int failures = 0;

    // Reference state: index 0 is the 64-bit instance, index 1 the 32-bit ZERO_R0 instance.
    logic [63:0] mreg [2][16];
    bit          mbusy [2][16];
    bit          mwaw [2];
    int          xl [2] = '{64, 32};
    bit          zr [2] = '{1'b0, 1'b1};

    regfile_sb #(.XLEN(64), .NREGS(16), .ZERO_R0(0)) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_width(wr_width),
        .wr_sext(wr_sext), .wr_data(wr_data), .rda_sel(rda_sel), .rdb_sel(rdb_sel),
        .rda_data(a_rda), .rdb_data(a_rdb), .busy_set(busy_set), .busy_sel(busy_sel),
        .rda_busy(a_rab), .rdb_busy(a_rbb), .any_busy(a_any), .waw_err(a_waw)
    );

    regfile_sb #(.XLEN(32), .NREGS(16), .ZERO_R0(1)) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_width(wr_width),
        .wr_sext(wr_sext), .wr_data(wr_data[31:0]), .rda_sel(rda_sel), .rdb_sel(rdb_sel),
        .rda_data(b_rda), .rdb_data(b_rdb), .busy_set(busy_set), .busy_sel(busy_sel),
        .rda_busy(b_rab), .rdb_busy(b_rbb), .any_busy(b_any), .waw_err(b_waw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Extend the low 8<<w bits of d (clipped to xlen) up to xlen bits.
    function automatic logic [63:0] ext(logic [63:0] d, logic [1:0] w, logic s, int xlen);
        int fb = 8 << w;
        logic [63:0] r = '0;
        if (fb > xlen) fb = xlen;
        for (int i = 0; i < xlen; i++) r[i] = (i < fb) ? d[i] : (s & d[fb-1]);
        return r;
    endfunction

    function automatic bit m_we(int k);
        return wr_en && !(zr[k] && wr_sel == 0);
    endfunction

    function automatic bit m_be(int k);
        return busy_set && !(zr[k] && busy_sel == 0);
    endfunction

    function automatic logic [63:0] m_rd(int k, logic [3:0] sel);
        if (zr[k] && sel == 0) return 64'd0;
        if (m_we(k) && wr_sel == sel) return ext(wr_data, wr_width, wr_sext, xl[k]);
        return mreg[k][sel];
    endfunction

    function automatic bit m_busy(int k, logic [3:0] sel);
        if (zr[k] && sel == 0) return 1'b0;
        if (m_we(k) && wr_sel == sel && !(m_be(k) && busy_sel == sel)) return 1'b0;
        return mbusy[k][sel];
    endfunction

    function automatic bit m_any(int k);
        bit r = 1'b0;
        for (int i = 0; i < 16; i++) r |= mbusy[k][i];
        return r;
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 16; i++) begin
                    mreg[k][i] = '0;
                    mbusy[k][i] = 1'b0;
                end
                mwaw[k] = 1'b0;
            end else begin
                if (m_be(k) && mbusy[k][busy_sel] && !(m_we(k) && wr_sel == busy_sel))
                    mwaw[k] = 1'b1;
                if (m_we(k)) begin
                    mreg[k][wr_sel] = ext(wr_data, wr_width, wr_sext, xl[k]);
                    mbusy[k][wr_sel] = 1'b0;
                end
                if (m_be(k)) mbusy[k][busy_sel] = 1'b1;
            end
        end
    endtask

    // Inputs were applied just after an edge; let them settle, then compare both instances.
    task automatic settle_and_check();
        #3;
        check("a_rda", a_rda, m_rd(0, rda_sel));
        check("a_rdb", a_rdb, m_rd(0, rdb_sel));
        check("a_rda_busy", {63'd0, a_rab}, {63'd0, m_busy(0, rda_sel)});
        check("a_rdb_busy", {63'd0, a_rbb}, {63'd0, m_busy(0, rdb_sel)});
        check("a_any_busy", {63'd0, a_any}, {63'd0, m_any(0)});
        check("a_waw_err", {63'd0, a_waw}, {63'd0, mwaw[0]});
        check("b_rda", {32'd0, b_rda}, m_rd(1, rda_sel));
        check("b_rdb", {32'd0, b_rdb}, m_rd(1, rdb_sel));
        check("b_rda_busy", {63'd0, b_rab}, {63'd0, m_busy(1, rda_sel)});
        check("b_rdb_busy", {63'd0, b_rbb}, {63'd0, m_busy(1, rdb_sel)});
        check("b_any_busy", {63'd0, b_any}, {63'd0, m_any(1)});
        check("b_waw_err", {63'd0, b_waw}, {63'd0, mwaw[1]});
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit rst, input bit we, input logic [3:0] ws, input logic [1:0] ww,
                         input bit sx, input logic [63:0] wd, input logic [3:0] ra,
                         input logic [3:0] rb, input bit bs, input logic [3:0] bsel);
        reset = rst; wr_en = we; wr_sel = ws; wr_width = ww; wr_sext = sx; wr_data = wd;
        rda_sel = ra; rdb_sel = rb; busy_set = bs; busy_sel = bsel;
    endtask

    typedef struct {
        bit          rst;
        bit          we;
        logic [3:0]  ws;
        logic [1:0]  ww;
        bit          sx;
        logic [63:0] wd;
        logic [3:0]  ra;
        bit          bs;
        logic [3:0]  bsel;
        logic [63:0] e_rda;
        bit          e_rab;
        bit          e_any;
        bit          e_waw;
    } vec_t;

    vec_t vecs [19];

    initial begin
        // Hand-computed pre-edge expectations for the 64-bit instance.
        vecs[0]  = '{1, 1, 2, 3, 0, 64'hAB, 3, 1, 4, 64'h0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 64'h0, 2, 0, 0, 64'h0, 0, 0, 0};
        vecs[2]  = '{0, 1, 3, 0, 1, 64'h1234_5680, 0, 0, 0, 64'h0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 64'h0, 3, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 0, 0, 0};
        vecs[4]  = '{0, 1, 3, 0, 0, 64'h80, 3, 0, 0, 64'h80, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 64'h0, 3, 0, 0, 64'h80, 0, 0, 0};
        vecs[6]  = '{0, 1, 5, 2, 0, 64'h1122_3344_5566_7788, 5, 0, 0, 64'h5566_7788, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 64'h0, 5, 0, 0, 64'h5566_7788, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 64'h0, 7, 1, 7, 64'h0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 64'h0, 7, 0, 0, 64'h0, 1, 1, 0};
        vecs[10] = '{0, 1, 7, 3, 0, 64'hDEAD, 7, 0, 0, 64'hDEAD, 0, 1, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 64'h0, 7, 0, 0, 64'hDEAD, 0, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 64'h0, 7, 1, 7, 64'hDEAD, 0, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 64'h0, 7, 1, 7, 64'hDEAD, 1, 1, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 64'h0, 7, 0, 0, 64'hDEAD, 1, 1, 1};
        vecs[15] = '{0, 1, 7, 1, 1, 64'h8001, 7, 1, 7, 64'hFFFF_FFFF_FFFF_8001, 1, 1, 1};
        vecs[16] = '{0, 0, 0, 0, 0, 64'h0, 7, 0, 0, 64'hFFFF_FFFF_FFFF_8001, 1, 1, 1};
        vecs[17] = '{1, 0, 0, 0, 0, 64'h0, 7, 0, 0, 64'hFFFF_FFFF_FFFF_8001, 1, 1, 1};
        vecs[18] = '{0, 0, 0, 0, 0, 64'h0, 7, 0, 0, 64'h0, 0, 0, 0};

        // Initial reset: outputs are undefined before it, so no comparisons here.
        drive(1, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0);
        #3;
        clock_edge();
        clock_edge();

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].ws, vecs[i].ww, vecs[i].sx, vecs[i].wd,
                  vecs[i].ra, 4'd4, vecs[i].bs, vecs[i].bsel);
            settle_and_check();
            check($sformatf("row%0d rda", i), a_rda, vecs[i].e_rda);
            check($sformatf("row%0d rda_busy", i), {63'd0, a_rab}, {63'd0, vecs[i].e_rab});
            check($sformatf("row%0d any_busy", i), {63'd0, a_any}, {63'd0, vecs[i].e_any});
            check($sformatf("row%0d waw_err", i), {63'd0, a_waw}, {63'd0, vecs[i].e_waw});
            clock_edge();
        end

        // Hard-wired r0 on the 32-bit instance.
        drive(0, 1, 0, 3, 0, 64'hFFFF, 0, 0, 0, 0);
        settle_and_check();
        check("r0 write bypass", {32'd0, b_rda}, 64'h0);
        clock_edge();
        drive(0, 0, 0, 0, 0, 64'h0, 0, 0, 1, 0);
        settle_and_check();
        check("r0 after write", {32'd0, b_rda}, 64'h0);
        clock_edge();
        drive(0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0);
        settle_and_check();
        check("r0 busy", {63'd0, b_rab}, 64'h0);
        check("r0 any_busy", {63'd0, b_any}, 64'h0);
        check("r0 waw_err", {63'd0, b_waw}, 64'h0);
        clock_edge();

        // Reset beats a same-cycle write and busy mark on both widths.
        drive(1, 1, 2, 3, 0, 64'h1_8765_4321, 2, 4, 1, 4);
        settle_and_check();
        check("b rst bypass", {32'd0, b_rda}, 64'h8765_4321);
        clock_edge();
        drive(0, 0, 0, 0, 0, 64'h0, 2, 4, 0, 0);
        settle_and_check();
        check("a r2 after rst", a_rda, 64'h0);
        check("a r4 busy after rst", {63'd0, a_rbb}, 64'h0);
        check("b r2 after rst", {32'd0, b_rda}, 64'h0);
        check("b r4 busy after rst", {63'd0, b_rbb}, 64'h0);
        clock_edge();
        drive(0, 1, 2, 3, 0, 64'h1_8765_4321, 0, 0, 0, 0);
        settle_and_check();
        clock_edge();
        drive(0, 0, 0, 0, 0, 64'h0, 2, 2, 0, 0);
        settle_and_check();
        check("a r2 width3", a_rda, 64'h0000_0001_8765_4321);
        check("b r2 width3", {32'd0, b_rda}, 64'h8765_4321);
        check("b portb same", {32'd0, b_rdb}, 64'h8765_4321);
        clock_edge();

        // Randomized traffic, selects biased toward a few registers to force collisions.
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] s [4];
            for (int j = 0; j < 4; j++)
                s[j] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3))
                                                  : 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 45), s[0],
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  s[1], s[2], ($urandom_range(0, 99) < 30), s[3]);
            settle_and_check();
            clock_edge();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
